// File: rtl/addsub8_pkg.sv
// Shared definitions for the add/sub arbiter: datapath width, unit mode codes, FSM states
// and the saturating counter helper used by the optional statistics block.
package addsub8_pkg;

  localparam int unsigned W_DATA = 8;
  localparam int unsigned STAT_W = 16;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; ptr names the port preferred when both are valid.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant[0] = valid[0] & (~valid[1] | ~ptr);
    grant[1] = valid[1] & (~valid[0] |  ptr);
  end

endmodule

// File: rtl/addsub8_arbiter.sv
// Shares one external combinational add/sub unit between two requesters, one op at a time.
// Optional per-port grant and overflow counters are built when ADDSUB8_ARB_STATS_EN is defined.
module addsub8_arbiter
  import addsub8_pkg::*;
#(
  parameter int unsigned W    = W_DATA,
  parameter int unsigned NREQ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_mode,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_carry,
  output logic              rsp_ovf,
`ifdef ADDSUB8_ARB_STATS_EN
  output logic [STAT_W-1:0] stat_grants0,
  output logic [STAT_W-1:0] stat_grants1,
  output logic [STAT_W-1:0] stat_ovf,
`endif
  output logic [W-1:0]      au_data0,
  output logic [W-1:0]      au_data1,
  output logic              au_mode,
  input  logic [W-1:0]      au_sum,
  input  logic              au_cout,
  input  logic              au_ovf
);

  state_e          state_q;
  logic            rr_q;
  logic            owner_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [W-1:0]    rsp_sum_q;
  logic            rsp_carry_q;
  logic            rsp_ovf_q;
  logic [W-1:0]    au_data0_q;
  logic [W-1:0]    au_data1_q;
  logic            au_mode_q;

  logic [1:0]      grant;
  logic            accept;
  logic            winner;
  logic            rsp_done;
  logic [NREQ-1:0] owner_oh;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            sel_mode;

  rr_arb2 u_rr_arb2 (
    .valid (req_valid),
    .ptr   (rr_q),
    .grant (grant)
  );

  always_comb begin
    req_ready = (state_q == StIdle) ? grant : '0;
    accept    = |(req_valid & req_ready);
    winner    = grant[1];
    sel_a     = winner ? req_a[W +: W] : req_a[0 +: W];
    sel_b     = winner ? req_b[W +: W] : req_b[0 +: W];
    sel_mode  = winner ? req_mode[1]   : req_mode[0];
    owner_oh  = '0;
    owner_oh[owner_q] = 1'b1;
    // Only the owner's bit of rsp_valid is ever set, so other ports' rsp_ready drop out here.
    rsp_done  = |(rsp_valid_q & rsp_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      au_data0_q  <= '0;
      au_data1_q  <= '0;
      au_mode_q   <= MODE_ADD;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            owner_q    <= winner;
            au_data0_q <= sel_a;
            au_data1_q <= sel_b;
            au_mode_q  <= sel_mode;
            state_q    <= StExec;
          end
        end
        StExec: begin
          rsp_sum_q   <= au_sum;
          rsp_carry_q <= au_cout;
          rsp_ovf_q   <= au_ovf;
          rsp_valid_q <= owner_oh;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_done) begin
            rsp_valid_q <= '0;
            rr_q        <= ~owner_q;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign au_data0  = au_data0_q;
  assign au_data1  = au_data1_q;
  assign au_mode   = au_mode_q;

`ifdef ADDSUB8_ARB_STATS_EN
  logic [STAT_W-1:0] stat_g0_q;
  logic [STAT_W-1:0] stat_g1_q;
  logic [STAT_W-1:0] stat_ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_g0_q  <= '0;
      stat_g1_q  <= '0;
      stat_ovf_q <= '0;
    end else begin
      if (accept && !winner) stat_g0_q <= sat_inc(stat_g0_q);
      if (accept &&  winner) stat_g1_q <= sat_inc(stat_g1_q);
      // Counted as the result is captured, matching what rsp_ovf will show.
      if (state_q == StExec && au_ovf) stat_ovf_q <= sat_inc(stat_ovf_q);
    end
  end

  assign stat_grants0 = stat_g0_q;
  assign stat_grants1 = stat_g1_q;
  assign stat_ovf     = stat_ovf_q;
`endif

endmodule
